// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: issues one read at a time, forwards the returned
// word to decode, and discards in-flight data when a redirect arrives.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RST_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    output logic        stall_if,
    output logic        ar_valid,
    output logic [31:0] ar_addr,
    input  logic        ar_ready,
    input  logic        r_valid,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    output logic        r_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    input  logic        inst_ready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        flush_pend, flush_d;
    logic        latch_pc;
    logic        capture;
    logic [31:0] addr_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        inst_err_q;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != 2'b00);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            flush_pend <= 1'b0;
        end else begin
            state_q    <= state_d;
            flush_pend <= flush_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        flush_d  = flush_pend;
        latch_pc = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                // A redirect this cycle means pc_i is about to change; wait for the target.
                if (!redirect_i) begin
                    latch_pc = 1'b1;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (ar_ready) begin
                    state_d = (flush_pend || redirect_i) ? DROP : DATA;
                    flush_d = 1'b0;
                end else if (redirect_i) begin
                    flush_d = 1'b1;
                end
            end
            DATA: begin
                if (r_valid) begin
                    if (redirect_i) begin
                        state_d = IDLE;
                    end else begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end else if (redirect_i) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (redirect_i || inst_ready) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (r_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= RST_PC;
            inst_q     <= 32'd0;
            inst_pc_q  <= RST_PC;
            inst_err_q <= 1'b0;
        end else begin
            if (latch_pc) begin
                addr_q <= pc_i;
            end
            if (capture) begin
                inst_q     <= r_data;
                inst_pc_q  <= addr_q;
                inst_err_q <= resp_is_err(r_resp);
            end
        end
    end

    assign ar_valid   = (state_q == ADDR);
    assign r_ready    = (state_q == DATA) || (state_q == DROP);
    assign inst_valid = (state_q == HOLD);
    assign ar_addr    = addr_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_err   = inst_err_q;

    // The PC counter moves only on a redirect or when decode takes the held instruction.
    assign stall_if = !(redirect_i || (!rst && (state_q == HOLD) && inst_ready));

endmodule
